packet_rr_scheduler: RTL and testbench
======================================

PACKET_RR_SCHEDULER -- requirements
Module: packet_rr_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of the stream payload.
REQ-002 Parameter ID_WIDTH / DEST_WIDTH / USER_WIDTH, 4 / 4 / 4, sideband widths; these are omitted under USE_LIGHT_STREAM.
REQ-003 Parameter CHANNEL_NUMBER, 5, number of requesting input streams.
REQ-004 Parameter MAX_PACKET_BEATS, 16, beat limit per granted packet before forced release.
REQ-005 Port clk, input, 1, the only clock; all logic is rising-edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port in, axis_if.s array, [CHANNEL_NUMBER], requester streams (tvalid, tready, tdata, tlast, tid, tdest, tuser).
REQ-008 Port out, axis_if.m, 1, the single shared output stream.
REQ-009 Port grant_idx, output, $clog2(CHANNEL_NUMBER), index of the current or last granted requester.
REQ-010 Port busy, output, 1, high while in state XFER.
REQ-011 Port overrun, output, 1, one-cycle pulse on forced release.

Function
REQ-012 The block SHALL implement the FSM states IDLE and XFER.
REQ-013 In IDLE with any in[i].tvalid high, it SHALL select the first valid requester searching from (last_grant+1) mod CHANNEL_NUMBER upward with wrap, latch it as the grant, and enter XFER on the next edge.
REQ-014 In IDLE, all in[i].tready and out.tvalid SHALL be 0, giving exactly one bubble cycle per packet.
REQ-015 In XFER, out payload, tlast and sideband SHALL equal in[grant] combinationally, out.tvalid SHALL equal in[grant].tvalid, in[grant].tready SHALL equal out.tready, and every other in[i].tready SHALL be 0.
REQ-016 A beat SHALL be accepted only when out.tvalid and out.tready are both high; a 10-bit-safe beat counter SHALL increment per accepted beat and clear on entry to XFER.
REQ-017 An accepted beat with tlast=1 SHALL return the FSM to IDLE on the next edge and set last_grant to grant.
REQ-018 When the counter reaches MAX_PACKET_BEATS accepted beats without tlast, the FSM SHALL return to IDLE, pulse overrun for one cycle, and advance last_grant; the remainder of that packet re-arbitrates as a new packet.
REQ-019 A single-beat packet (tlast on its first beat) SHALL occupy exactly 2 cycles: IDLE, then XFER.
REQ-020 A grant SHALL NOT change while in XFER, regardless of other tvalids; a stalled out.tready SHALL hold state indefinitely with no counter change.
REQ-021 A requester dropping tvalid mid-packet SHALL keep its grant; there is no timeout other than REQ-018.
REQ-022 With CHANNEL_NUMBER requesters continuously valid, each SHALL be granted once per CHANNEL_NUMBER packets in strict rotation.

Reset
REQ-023 When rst is high at a rising edge, the block SHALL force state IDLE, beat counter 0, and last_grant CHANNEL_NUMBER-1, so that requester 0 has first priority after reset.
REQ-024 After reset, busy and overrun SHALL be 0, grant_idx SHALL be 0, and all in[i].tready and out.tvalid SHALL be 0.
REQ-025 Reset asserted mid-packet SHALL abandon the packet with no recovery; beats already accepted are not replayed.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, XFER) and a function that computes the round-robin next index.
REQ-027 One sub-module, rr_pick, SHALL compute the combinational rotate-priority select from the valid vector and last_grant.

Verification
REQ-028 After reset, in[0] and in[3] are valid with 3-beat packets -> the bench SHALL see grant 0 first, then 3; output beats in order; one bubble before each packet.
REQ-029 All 5 requesters are continuously valid with 1-beat packets -> the bench SHALL see the grant sequence 0,1,2,3,4,0 with an output beat every 2nd cycle.
REQ-030 out.tready is held low for 4 cycles mid-packet -> the bench SHALL see grant, counter and payload stable, no lost or duplicated beat, and other requesters' tready low.
REQ-031 in[2] sends 20 beats without tlast and MAX_PACKET_BEATS=16 -> the bench SHALL see an overrun pulse after beat 16, a return to IDLE, and the remaining 4 beats delivered under a later grant.
REQ-032 rst is asserted on beat 2 of a 5-beat packet -> on the next cycle the bench SHALL see state IDLE, busy 0, outputs per REQ-024, and the next grant going to requester 0 if it is valid.

Source files
------------

// File: rtl/packet_rr_scheduler_pkg.sv
// Shared types and the round-robin index step used by the packet scheduler.
package packet_rr_scheduler_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream bundle with id/dest/user sideband.
interface axis_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 4
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;
   logic [ID_WIDTH-1:0]   tid;
   logic [DEST_WIDTH-1:0] tdest;
   logic [USER_WIDTH-1:0] tuser;

   modport m (output tvalid, tdata, tlast, tid, tdest, tuser, input tready);
   modport s (input tvalid, tdata, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/packet_rr_scheduler_rr_pick.sv
// Rotating-priority picker: first valid index after i_last_grant, wrapping.
module rr_pick
   import packet_rr_scheduler_pkg::*;
#(
   parameter int N  = 5,
   parameter int GW = $clog2(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [GW-1:0] i_last_grant,
   output logic          o_any,
   output logic [GW-1:0] o_idx
);
   logic [GW-1:0] w_cand;

   always_comb begin
      o_any  = 1'b0;
      o_idx  = '0;
      w_cand = GW'(rr_next(int'(i_last_grant), N));
      for (int k = 0; k < N; k++) begin
         if (!o_any && i_valid[w_cand]) begin
            o_any = 1'b1;
            o_idx = w_cand;
         end
         w_cand = GW'(rr_next(int'(w_cand), N));
      end
   end
endmodule

// File: rtl/packet_rr_scheduler.sv
// Packet-granular round-robin mux of CHANNEL_NUMBER AXI streams onto one output,
// with one arbitration bubble per packet and forced release after MAX_PACKET_BEATS.
module packet_rr_scheduler
   import packet_rr_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int ID_WIDTH         = 4,
   parameter int DEST_WIDTH       = 4,
   parameter int USER_WIDTH       = 4,
   parameter int CHANNEL_NUMBER   = 5,
   parameter int MAX_PACKET_BEATS = 16,
   parameter bit USE_LIGHT_STREAM = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst,
   axis_if.s                                 in [CHANNEL_NUMBER],
   axis_if.m                                 out,
   output logic [$clog2(CHANNEL_NUMBER)-1:0] grant_idx,
   output logic                              busy,
   output logic                              overrun
);
   localparam int            GW        = $clog2(CHANNEL_NUMBER);
   localparam logic [GW-1:0] LAST_IDX  = GW'(CHANNEL_NUMBER - 1);
   localparam logic [9:0]    MAX_BEATS = 10'(MAX_PACKET_BEATS);

   state_e        r_state, w_next_state;
   logic [GW-1:0] r_grant, r_last_grant, w_pick;
   logic [9:0]    r_cnt;
   logic          r_overrun, w_any, w_accept, w_force;

   logic [CHANNEL_NUMBER-1:0]                 w_valid, w_last;
   logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0] w_data;
   logic [CHANNEL_NUMBER-1:0][ID_WIDTH-1:0]   w_id;
   logic [CHANNEL_NUMBER-1:0][DEST_WIDTH-1:0] w_dest;
   logic [CHANNEL_NUMBER-1:0][USER_WIDTH-1:0] w_user;

   // Interface arrays only take constant indices, so flatten them first.
   for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_ch
      assign w_valid[g]   = in[g].tvalid;
      assign w_last[g]    = in[g].tlast;
      assign w_data[g]    = in[g].tdata;
      assign w_id[g]      = in[g].tid;
      assign w_dest[g]    = in[g].tdest;
      assign w_user[g]    = in[g].tuser;
      assign in[g].tready = busy && (r_grant == GW'(g)) && out.tready;
   end

   rr_pick #(.N(CHANNEL_NUMBER), .GW(GW)) u_pick (
      .i_valid      (w_valid),
      .i_last_grant (r_last_grant),
      .o_any        (w_any),
      .o_idx        (w_pick)
   );

   assign busy      = (r_state == XFER);
   assign overrun   = r_overrun;
   assign grant_idx = r_grant;

   assign out.tvalid = busy && w_valid[r_grant];
   assign out.tdata  = w_data[r_grant];
   assign out.tlast  = w_last[r_grant];
   assign out.tid    = USE_LIGHT_STREAM ? '0 : w_id[r_grant];
   assign out.tdest  = USE_LIGHT_STREAM ? '0 : w_dest[r_grant];
   assign out.tuser  = USE_LIGHT_STREAM ? '0 : w_user[r_grant];

   assign w_accept = busy && w_valid[r_grant] && out.tready;
   assign w_force  = w_accept && !w_last[r_grant] && (r_cnt + 10'd1 == MAX_BEATS);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_any) w_next_state = XFER;
         XFER:    if (w_accept && (w_last[r_grant] || w_force)) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // Counter is held at zero through IDLE, so it is clear on every XFER entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_grant      <= '0;
         r_last_grant <= LAST_IDX;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= w_force;
         if (r_state == IDLE) begin
            r_cnt <= '0;
            if (w_any) r_grant <= w_pick;
         end else if (w_accept) begin
            r_cnt <= r_cnt + 10'd1;
            if (w_last[r_grant] || w_force) r_last_grant <= r_grant;
         end
      end
   end
endmodule

// File: tb/tb_packet_rr_scheduler.sv
// Scoreboard bench for packet_rr_scheduler: per-channel packet sources, expected beats queued with their cycle.
module tb_packet_rr_scheduler;
   localparam int CH = 5;

   typedef struct {
      int   ch;
      int   idx;
      logic last;
      int   t;
   } exp_t;

   logic clk, rst;
   logic [2:0] grant_idx;
   logic busy, overrun;
   logic tb_out_ready;
   logic [CH-1:0] tb_valid, tb_last, tb_ready;
   logic [CH-1:0][31:0] tb_data;
   logic [CH-1:0][3:0] tb_id, tb_dest, tb_user;

   axis_if in_if [CH] ();
   axis_if out_if ();

   for (genvar g = 0; g < CH; g++) begin : g_src
      assign in_if[g].tvalid = tb_valid[g];
      assign in_if[g].tdata  = tb_data[g];
      assign in_if[g].tlast  = tb_last[g];
      assign in_if[g].tid    = tb_id[g];
      assign in_if[g].tdest  = tb_dest[g];
      assign in_if[g].tuser  = tb_user[g];
      assign tb_ready[g]     = in_if[g].tready;
   end
   assign out_if.tready = tb_out_ready;

   packet_rr_scheduler #(.CHANNEL_NUMBER(CH), .MAX_PACKET_BEATS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in_if),
      .out       (out_if),
      .grant_idx (grant_idx),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks, errors, cyc, t0, stall_lo, stall_hi;
   logic src_last [CH][64];
   int src_len [CH];
   int src_ptr [CH];
   exp_t exp_q [$];

   int s_t;
   logic s_busy, s_ovr, s_tvalid;
   logic [2:0] s_grant;
   logic [31:0] s_tdata;
   logic [CH-1:0] s_ready;

   function automatic logic [31:0] mk_data(input int ch, input int idx);
      return 32'hA000_0000 | (32'(ch) << 16) | 32'(idx);
   endfunction

   task automatic add_src(input int ch, input int n, input bit with_last);
      for (int k = 0; k < n; k++) src_last[ch][src_len[ch] + k] = with_last && (k == n - 1);
      src_len[ch] += n;
   endtask

   task automatic push_exp(input int ch, input int idx, input bit last, input int t);
      exp_t e;
      e.ch = ch; e.idx = idx; e.last = last; e.t = t;
      exp_q.push_back(e);
   endtask

   // One clock: drive sources, sample at negedge, score any handshake, advance sources.
   task automatic tick();
      int src_ch;
      exp_t e;
      for (int i = 0; i < CH; i++) begin
         tb_valid[i] = src_ptr[i] < src_len[i];
         tb_last[i]  = tb_valid[i] ? src_last[i][src_ptr[i]] : 1'b0;
         tb_data[i]  = mk_data(i, src_ptr[i]);
         tb_id[i]    = 4'(i);
         tb_dest[i]  = 4'(src_ptr[i]);
         tb_user[i]  = 4'(i + src_ptr[i]);
      end
      s_t = cyc - t0;
      tb_out_ready = !(s_t >= stall_lo && s_t < stall_hi);
      @(negedge clk);
      s_busy = busy; s_ovr = overrun; s_grant = grant_idx;
      s_tvalid = out_if.tvalid; s_tdata = out_if.tdata; s_ready = tb_ready;
      src_ch = -1;
      for (int i = 0; i < CH; i++) if (tb_valid[i] && tb_ready[i]) src_ch = i;
      if (out_if.tvalid && out_if.tready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected t=%0d data=%h grant=%0d", s_t, out_if.tdata, grant_idx);
         end else begin
            e = exp_q.pop_front();
            if (out_if.tdata !== mk_data(e.ch, e.idx) || out_if.tlast !== e.last ||
                out_if.tid !== 4'(e.ch) || out_if.tdest !== 4'(e.idx) ||
                out_if.tuser !== 4'(e.ch + e.idx) || grant_idx !== 3'(e.ch) ||
                src_ch != e.ch || s_t != e.t) begin
               errors++;
               $display("FAIL beat ch%0d/%0d: got data=%h last=%b grant=%0d src=%0d t=%0d, want data=%h last=%b t=%0d",
                        e.ch, e.idx, out_if.tdata, out_if.tlast, grant_idx, src_ch, s_t,
                        mk_data(e.ch, e.idx), e.last, e.t);
            end
         end
      end else if (src_ch >= 0) begin
         checks++; errors++;
         $display("FAIL input_handshake_without_output t=%0d ch=%0d", s_t, src_ch);
      end
      @(posedge clk); #1;
      if (src_ch >= 0) src_ptr[src_ch]++;
      cyc++;
   endtask

   task automatic do_reset();
      for (int i = 0; i < CH; i++) begin src_len[i] = 0; src_ptr[i] = 0; end
      exp_q.delete();
      stall_lo = 0; stall_hi = 0;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      t0 = cyc;
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s missing_beats got=%0d outstanding, want 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      checks++;
      if (s_busy !== 1'b0 || s_ovr !== 1'b0 || s_grant !== 3'd0) begin
         errors++;
         $display("FAIL reset_state busy=%b overrun=%b grant=%0d, want 0 0 0", s_busy, s_ovr, s_grant);
      end
      checks++;
      if (s_tvalid !== 1'b0 || s_ready !== '0) begin
         errors++;
         $display("FAIL reset_handshake tvalid=%b tready=%b, want 0 00000", s_tvalid, s_ready);
      end
   endtask

   task automatic test_two_requesters();
      do_reset();
      add_src(0, 3, 1'b1); add_src(3, 3, 1'b1);
      push_exp(0, 0, 0, 1); push_exp(0, 1, 0, 2); push_exp(0, 2, 1, 3);
      push_exp(3, 0, 0, 5); push_exp(3, 1, 0, 6); push_exp(3, 2, 1, 7);
      for (int k = 0; k < 9; k++) tick();
      check_drained("two_requesters");
   endtask

   task automatic test_rotation();
      do_reset();
      for (int c = 0; c < CH; c++) begin add_src(c, 1, 1'b1); add_src(c, 1, 1'b1); end
      for (int p = 0; p < 2; p++)
         for (int c = 0; c < CH; c++) push_exp(c, p, 1, 1 + 2 * (p * CH + c));
      for (int k = 0; k < 21; k++) tick();
      check_drained("rotation");
   endtask

   task automatic test_stall();
      do_reset();
      add_src(1, 5, 1'b1); add_src(2, 2, 1'b1);
      stall_lo = 3; stall_hi = 7;
      push_exp(1, 0, 0, 1); push_exp(1, 1, 0, 2); push_exp(1, 2, 0, 7);
      push_exp(1, 3, 0, 8); push_exp(1, 4, 1, 9);
      push_exp(2, 0, 0, 11); push_exp(2, 1, 1, 12);
      for (int k = 0; k < 14; k++) begin
         tick();
         if (s_t >= 3 && s_t < 7) begin
            checks++;
            if (s_busy !== 1'b1 || s_grant !== 3'd1 || s_tvalid !== 1'b1 ||
                s_tdata !== mk_data(1, 2) || s_ready !== '0) begin
               errors++;
               $display("FAIL stall_hold t=%0d busy=%b grant=%0d tvalid=%b data=%h tready=%b, want 1 1 1 %h 00000",
                        s_t, s_busy, s_grant, s_tvalid, s_tdata, s_ready, mk_data(1, 2));
            end
         end
      end
      check_drained("stall");
   endtask

   task automatic test_overrun();
      int ovr_n, ovr_t;
      logic ovr_busy;
      ovr_n = 0; ovr_t = -1; ovr_busy = 1'bx;
      do_reset();
      add_src(2, 20, 1'b1); add_src(3, 1, 1'b1);
      for (int b = 0; b < 16; b++) push_exp(2, b, 0, 1 + b);
      push_exp(3, 0, 1, 18);
      for (int b = 16; b < 20; b++) push_exp(2, b, b == 19, 4 + b);
      for (int k = 0; k < 25; k++) begin
         tick();
         if (s_ovr === 1'b1) begin ovr_n++; ovr_t = s_t; ovr_busy = s_busy; end
      end
      checks++;
      if (ovr_n != 1 || ovr_t != 17 || ovr_busy !== 1'b0) begin
         errors++;
         $display("FAIL overrun_pulse count=%0d t=%0d busy=%b, want 1 17 0", ovr_n, ovr_t, ovr_busy);
      end
      check_drained("overrun");
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      add_src(1, 5, 1'b1);
      push_exp(1, 0, 0, 1); push_exp(1, 1, 0, 2); push_exp(1, 2, 0, 3);
      for (int k = 0; k < 10; k++) begin
         rst = (k == 3);
         tick();
         if (k == 3) begin
            add_src(0, 1, 1'b1);
            push_exp(0, 0, 1, 5); push_exp(1, 3, 0, 7); push_exp(1, 4, 1, 8);
         end
         if (k == 4) begin
            checks++;
            if (s_busy !== 1'b0 || s_ovr !== 1'b0 || s_grant !== 3'd0 ||
                s_tvalid !== 1'b0 || s_ready !== '0) begin
               errors++;
               $display("FAIL reset_mid_packet busy=%b overrun=%b grant=%0d tvalid=%b tready=%b, want 0 0 0 0 00000",
                        s_busy, s_ovr, s_grant, s_tvalid, s_ready);
            end
         end
      end
      rst = 1'b0;
      check_drained("reset_mid_packet");
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; t0 = 0;
      stall_lo = 0; stall_hi = 0;
      rst = 1'b1; tb_out_ready = 1'b1;
      tb_valid = '0; tb_last = '0; tb_data = '0; tb_id = '0; tb_dest = '0; tb_user = '0;
      for (int i = 0; i < CH; i++) begin src_len[i] = 0; src_ptr[i] = 0; end
      test_reset();
      test_two_requesters();
      test_rotation();
      test_stall();
      test_overrun();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
